// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter on the core's data-memory bus.
//
// Stores to the register window are decoded from MemWrite/ALUResult/WriteData.
// Bytes written to TXDATA are queued in a FIFO and serialised LSB first on tx.
// ReadData and Sel are purely combinational from ALUResult. An external mux uses
// Sel to merge ReadData into the core's read path.
//
// Register map (offset = ALUResult[3:2]):
//   0 TXDATA  W: push WriteData[7:0] (dropped and OVF set when full); reads 0
//   1 STATUS  R: {count[11:8], OVF[3], BUSY[2], EMPTY[1], FULL[0]}; W1C of bit3
//   2 CTRL    RW: bit0 EN, bit1 IRQEN
//   3 reserved: reads 0, writes ignored
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   MemWrite   core store strobe
//   ALUResult  core data address
//   WriteData  core store data
//   ReadData   register read value (0 when Sel is low)
//   Sel        address falls inside the register window
//   tx         serial output, idle high, registered
//   irq        TX-done interrupt: IRQEN & EMPTY & ~BUSY

module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int unsigned CLK_DIV    = 16,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Sel,
    output logic        tx,
    output logic        irq
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(CLK_DIV);

    localparam logic [TW-1:0] TimerReload = TW'(CLK_DIV - 1);
    localparam logic [CW-1:0] DepthCount  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic [1:0] offset;
    logic       wr_txdata;
    logic       wr_status;
    logic       wr_ctrl;

    assign Sel       = (ALUResult[31:4] == BASE_ADDR[31:4]);
    assign offset    = ALUResult[3:2];
    assign wr_txdata = MemWrite & Sel & (offset == 2'd0);
    assign wr_status = MemWrite & Sel & (offset == 2'd1);
    assign wr_ctrl   = MemWrite & Sel & (offset == 2'd2);

    // Address bits [1:0] and upper store-data bits carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{ALUResult[1:0], WriteData[31:8]};

    // ------------------------------------------------------------------
    // Control / status registers
    // ------------------------------------------------------------------
    logic en_q, en_d;
    logic irqen_q, irqen_d;
    logic ovf_q, ovf_d;

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    assign full  = (count_q == DepthCount);
    assign empty = (count_q == '0);
    // Full is judged on the pre-edge count, so a same-edge pop never rescues a push.
    assign push  = wr_txdata & ~full;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    // Storage needs no reset: entries are only read below the valid count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= WriteData[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            // Pointers wrap naturally because FIFO_DEPTH is a power of two.
            if (push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    always_comb begin
        en_d    = en_q;
        irqen_d = irqen_q;
        ovf_d   = ovf_q;
        if (wr_ctrl) begin
            en_d    = WriteData[0];
            irqen_d = WriteData[1];
        end
        if (wr_txdata && full) begin
            ovf_d = 1'b1;
        end else if (wr_status && WriteData[3]) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_q    <= 1'b0;
            irqen_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            en_q    <= en_d;
            irqen_q <= irqen_d;
            ovf_q   <= ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          tx_q, tx_d;
    logic          launch;
    logic          busy;

    // EN is sampled pre-edge, so a CTRL store in the decision cycle has no say yet.
    assign launch = en_q & ~empty;

    // tx_d is the line level for the state being entered, keeping tx registered.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        tx_d     = tx_q;
        pop      = 1'b0;

        case (state_q)
            StIdle: begin
                tx_d = 1'b1;
                if (launch) begin
                    pop     = 1'b1;
                    shreg_d = mem_q[rptr_q];
                    state_d = StStart;
                    timer_d = TimerReload;
                    tx_d    = 1'b0;
                end
            end

            StStart: begin
                if (timer_q == '0) begin
                    state_d  = StData;
                    timer_d  = TimerReload;
                    bitcnt_d = 3'd0;
                    tx_d     = shreg_q[0];
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end

            StData: begin
                if (timer_q == '0) begin
                    timer_d = TimerReload;
                    if (bitcnt_q == 3'd7) begin
                        state_d = StStop;
                        tx_d    = 1'b1;
                    end else begin
                        bitcnt_d = bitcnt_q + 3'd1;
                        shreg_d  = {1'b0, shreg_q[7:1]};
                        tx_d     = shreg_q[1];
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end

            StStop: begin
                if (timer_q == '0) begin
                    // Chain straight into the next start bit so frames have no gap.
                    if (launch) begin
                        pop     = 1'b1;
                        shreg_d = mem_q[rptr_q];
                        state_d = StStart;
                        timer_d = TimerReload;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = StIdle;
                        tx_d    = 1'b1;
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end

            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            timer_q  <= '0;
            bitcnt_q <= '0;
            shreg_q  <= '0;
            tx_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
            tx_q     <= tx_d;
        end
    end

    assign busy = (state_q != StIdle);
    assign tx   = tx_q;
    assign irq  = irqen_q & empty & ~busy;

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic [3:0]  count_field;
    logic [31:0] status_word;

    assign count_field = 4'(count_q);
    assign status_word = {20'd0, count_field, 4'd0, ovf_q, busy, empty, full};

    always_comb begin
        ReadData = '0;
        if (Sel) begin
            case (offset)
                2'd1:    ReadData = status_word;
                2'd2:    ReadData = {30'd0, irqen_q, en_q};
                default: ReadData = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx with CLK_DIV=4, FIFO_DEPTH=8.
// A queue-based reference model predicts tx, irq, Sel and ReadData every cycle;
// constant vectors and hand sequences cover reset, framing, fill/overflow,
// drain, EN-off mid-frame, reset mid-frame, decode and irq.

module tb_mmio_uart_tx;

    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int          D     = 4;
    localparam int          DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] ALUResult = 32'd0;
    logic [31:0] WriteData = 32'd0;
    logic [31:0] ReadData;
    logic        Sel;
    logic        tx;
    logic        irq;

    mmio_uart_tx #(
        .BASE_ADDR (BASE),
        .CLK_DIV   (D),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .MemWrite (MemWrite),
        .ALUResult(ALUResult),
        .WriteData(WriteData),
        .ReadData (ReadData),
        .Sel      (Sel),
        .tx       (tx),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] m_q[$];
    bit         m_en, m_irqen, m_ovf, m_busy;
    int         m_pos;
    logic [7:0] m_cur;

    task automatic model_reset();
        m_q.delete();
        m_en = 0; m_irqen = 0; m_ovf = 0; m_busy = 0; m_pos = 0; m_cur = 8'd0;
    endtask

    // Cycle m_pos of a frame carries bit m_pos/D of {stop, data[7:0], start}.
    function automatic logic m_tx();
        int idx;
        if (!m_busy) return 1'b1;
        idx = m_pos / D;
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return m_cur[idx-1];
    endfunction

    function automatic logic m_irq();
        return m_irqen && (m_q.size() == 0) && !m_busy;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] addr);
        logic [31:0] s;
        int          c;
        s = 32'd0;
        if (addr[31:4] != BASE[31:4]) return 32'd0;
        c = m_q.size();
        case (addr[3:2])
            2'd1: begin
                s[0]    = (c == DEPTH);
                s[1]    = (c == 0);
                s[2]    = m_busy;
                s[3]    = m_ovf;
                s[11:8] = 4'(c);
            end
            2'd2: s = {30'd0, m_irqen, m_en};
            default: s = 32'd0;
        endcase
        return s;
    endfunction

    // Apply one clock edge using the inputs as they stood before it.
    task automatic model_edge();
        int  cnt;
        bit  hit;
        cnt = m_q.size();
        hit = (ALUResult[31:4] == BASE[31:4]);
        if (!m_busy) begin
            if (m_en && cnt > 0) begin
                m_cur = m_q.pop_front(); m_busy = 1; m_pos = 0;
            end
        end else if (m_pos == 10 * D - 1) begin
            if (m_en && cnt > 0) begin
                m_cur = m_q.pop_front(); m_pos = 0;
            end else begin
                m_busy = 0;
            end
        end else begin
            m_pos++;
        end
        if (MemWrite && hit) begin
            case (ALUResult[3:2])
                2'd0: if (cnt == DEPTH) m_ovf = 1; else m_q.push_back(WriteData[7:0]);
                2'd1: if (WriteData[3]) m_ovf = 0;
                2'd2: begin m_en = WriteData[0]; m_irqen = WriteData[1]; end
                default: ;
            endcase
        end
    endtask

    // ---------------- drivers ----------------
    task automatic bus(input logic we, input logic [31:0] addr, input logic [31:0] data);
        MemWrite = we; ALUResult = addr; WriteData = data;
    endtask

    task automatic sample();
        @(negedge clk);
        chk("model_tx", 32'(tx), 32'(m_tx()));
        chk("model_irq", 32'(irq), 32'(m_irq()));
        chk("model_sel", 32'(Sel), 32'(ALUResult[31:4] == BASE[31:4]));
        chk("model_rdata", ReadData, m_read(ALUResult));
    endtask

    task automatic adv();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        bus(1'b1, addr, data); sample(); adv();
        bus(1'b0, BASE + 32'h4, 32'd0);
    endtask

    task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
        bus(1'b0, addr, 32'd0); sample(); chk(name, ReadData, exp); adv();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin sample(); adv(); end
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_sel;
    } vec_t;

    vec_t       vecs[12];
    logic [9:0] frame;
    bit         seen;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Reset state
        bus(1'b0, BASE + 32'h4, 32'd0);
        sample();
        chk("reset_tx", 32'(tx), 32'd1);
        chk("reset_irq", 32'(irq), 32'd0);
        chk("reset_status", ReadData, 32'h2);
        adv();

        // Register decode table
        vecs[0]  = '{1'b0, BASE + 32'h4,  32'd0,         32'h2, 1'b1};
        vecs[1]  = '{1'b0, BASE + 32'h8,  32'd0,         32'h0, 1'b1};
        vecs[2]  = '{1'b0, BASE,          32'd0,         32'h0, 1'b1};
        vecs[3]  = '{1'b0, BASE + 32'hC,  32'd0,         32'h0, 1'b1};
        vecs[4]  = '{1'b1, BASE + 32'h10, 32'd1,         32'h0, 1'b0};
        vecs[5]  = '{1'b0, BASE + 32'h8,  32'd0,         32'h0, 1'b1};
        vecs[6]  = '{1'b1, BASE + 32'h8,  32'hFFFF_FFF6, 32'h0, 1'b1};
        vecs[7]  = '{1'b0, BASE + 32'h9,  32'd0,         32'h2, 1'b1};
        vecs[8]  = '{1'b0, BASE + 32'h4,  32'd0,         32'h2, 1'b1};
        vecs[9]  = '{1'b1, BASE + 32'h8,  32'd0,         32'h2, 1'b1};
        vecs[10] = '{1'b0, 32'h2000_0004, 32'd0,         32'h0, 1'b0};
        vecs[11] = '{1'b1, BASE + 32'hC,  32'hFFFF_FFFF, 32'h0, 1'b1};
        for (int i = 0; i < 12; i++) begin
            bus(vecs[i].we, vecs[i].addr, vecs[i].wdata);
            sample();
            chk($sformatf("vec%0d_rdata", i), ReadData, vecs[i].exp_rd);
            chk($sformatf("vec%0d_sel", i), 32'(Sel), 32'(vecs[i].exp_sel));
            adv();
        end
        rd_chk("ctrl_after_table", BASE + 32'h8, 32'h0);

        // Single byte 0xA5
        wr(BASE + 32'h8, 32'h1);
        bus(1'b1, BASE, 32'hA5); sample(); adv();
        bus(1'b0, BASE + 32'h4, 32'd0);
        sample(); chk("a5_latency_high", 32'(tx), 32'd1); adv();
        frame = {1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < 10 * D; i++) begin
            sample();
            chk($sformatf("a5_bit%0d", i / D), 32'(tx), 32'(frame[i / D]));
            if (i == 10 * D - 1) chk("a5_busy_last", 32'(ReadData[2]), 32'd1);
            adv();
        end
        rd_chk("a5_idle_status", BASE + 32'h4, 32'h2);

        // Fill with EN=0, overflow, clear
        wr(BASE + 32'h8, 32'h0);
        for (int k = 0; k < 8; k++) wr(BASE, k);
        rd_chk("fill_status", BASE + 32'h4, 32'h801);
        wr(BASE, 32'hEE);
        rd_chk("ovf_status", BASE + 32'h4, 32'h809);
        wr(BASE + 32'h4, 32'h8);
        rd_chk("ovf_clear", BASE + 32'h4, 32'h801);

        // Drain: 8 back-to-back frames
        wr(BASE + 32'h8, 32'h1);
        sample(); chk("drain_latency_high", 32'(tx), 32'd1); adv();
        for (int i = 0; i < 8 * 10 * D; i++) begin
            frame = {1'b1, 8'(i / (10 * D)), 1'b0};
            sample();
            chk($sformatf("drain_b%0d", i / (10 * D)), 32'(tx), 32'(frame[(i % (10 * D)) / D]));
            adv();
        end
        rd_chk("drain_empty", BASE + 32'h4, 32'h2);

        // EN cleared mid-frame with two bytes queued
        wr(BASE, 32'h3C);
        wr(BASE, 32'hC3);
        idle_cycles(8);
        wr(BASE + 32'h8, 32'h0);
        idle_cycles(60);
        sample(); chk("enoff_tx_idle", 32'(tx), 32'd1); adv();
        rd_chk("enoff_status", BASE + 32'h4, 32'h100);

        // Reset mid-frame
        wr(BASE + 32'h8, 32'h1);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            sample();
            if (tx === 1'b0) seen = 1; else adv();
        end
        chk("rst_frame_started", 32'(seen), 32'd1);
        adv(); adv();
        #1 reset = 1'b0;
        model_reset();
        #1 chk("rst_tx_immediate", 32'(tx), 32'd1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        rd_chk("rst_status", BASE + 32'h4, 32'h2);
        rd_chk("rst_ctrl", BASE + 32'h8, 32'h0);

        // Decode and irq
        wr(BASE + 32'h8, 32'h2);
        sample(); chk("irq_idle_empty", 32'(irq), 32'd1); adv();
        bus(1'b1, BASE + 32'h10, 32'h3); sample();
        chk("oow_sel", 32'(Sel), 32'd0);
        chk("oow_rdata", ReadData, 32'd0);
        adv();
        rd_chk("oow_ctrl_kept", BASE + 32'h8, 32'h2);
        wr(BASE + 32'h8, 32'h3);
        bus(1'b1, BASE, 32'h5A); adv();
        bus(1'b0, BASE + 32'h4, 32'd0);
        for (int i = 0; i <= 10 * D; i++) begin
            sample(); chk("irq_low_busy", 32'(irq), 32'd0); adv();
        end
        sample(); chk("irq_after_stop", 32'(irq), 32'd1); adv();

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            int          r;
            logic [31:0] a;
            r = $urandom_range(0, 99);
            a = BASE + {26'd0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'd0};
            if (r < 30) begin
                bus(1'b1, BASE | 32'($urandom_range(0, 3)), $urandom);
            end else if (r < 38) begin
                bus(1'b1, BASE + 32'h8,
                    {$urandom_range(0, 1) == 1 ? 30'h3FFF_FFFF : 30'd0,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0)});
            end else if (r < 42) begin
                bus(1'b1, BASE + 32'h4, $urandom);
            end else if (r < 47) begin
                bus(1'b1, BASE ^ (32'h10 << $urandom_range(0, 27)), $urandom);
            end else begin
                bus(1'b0, a, $urandom);
            end
            sample();
            adv();
        end
        bus(1'b0, BASE + 32'h4, 32'd0);
        idle_cycles(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
